// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM state type and scale constant for the GBA audio mixer.
package audio_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUTPUT} state_e;
    localparam int SCALE_SHIFT = 3;
endpackage

// File: rtl/audio_sat.sv
// audio_sat: saturates a signed IN_W value to the signed OUT_W range.
module audio_sat #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 24
) (
    input  logic [IN_W-1:0]  d_i,
    output logic [OUT_W-1:0] q_o
);
    generate
        if (IN_W > OUT_W) begin : g_sat
            logic [IN_W-OUT_W:0] hi;
            assign hi  = d_i[IN_W-1:OUT_W-1];
            assign q_o = (&hi || ~|hi) ? d_i[OUT_W-1:0] : {d_i[IN_W-1], {(OUT_W-1){~d_i[IN_W-1]}}};
        end else begin : g_ext
            assign q_o = OUT_W'($signed(d_i));
        end
    endgenerate
endmodule

// File: rtl/gba_audio_mixer.sv
// gba_audio_mixer: per-tick sequential mix of NUM_CH channels into a
// saturated, master-scaled stereo pair with a valid/ready output stage.
module gba_audio_mixer
    import audio_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 24
) (
    input  logic                   clk_100,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   power_en,
    input  logic [NUM_CH*IN_W-1:0] ch_sample,
    input  logic [NUM_CH*4-1:0]    ch_vol,
    input  logic [NUM_CH-1:0]      ch_en_l,
    input  logic [NUM_CH-1:0]      ch_en_r,
    input  logic [2:0]             master_l,
    input  logic [2:0]             master_r,
    input  logic                   clr_overrun,
    output logic [OUT_W-1:0]       out_l,
    output logic [OUT_W-1:0]       out_r,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun
);
    localparam int ACC_W = IN_W + 5 + $clog2(NUM_CH) + 3;
    localparam int PW    = IN_W + 5;
    localparam int SW    = ACC_W + 5;
    localparam int KW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    state_e                   state_q;
    logic [KW-1:0]            k_q;
    logic signed [ACC_W-1:0]  acc_l_q, acc_r_q;
    logic [NUM_CH*IN_W-1:0]   samp_q;
    logic [NUM_CH*4-1:0]      vol_q;
    logic [NUM_CH-1:0]        en_l_q, en_r_q;
    logic [2:0]               mst_l_q, mst_r_q;
    logic [OUT_W-1:0]         out_l_q, out_r_q;
    logic                     out_valid_q, overrun_q;

    logic signed [IN_W-1:0]   smp;
    logic [3:0]               vol;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  add_l, add_r;
    logic signed [SW-1:0]     sc_l, sc_r;
    logic [OUT_W-1:0]         sat_l, sat_r;

    assign smp   = samp_q[int'(k_q)*IN_W +: IN_W];
    assign vol   = vol_q[int'(k_q)*4 +: 4];
    assign prod  = PW'(smp) * PW'($signed({1'b0, vol}));
    assign add_l = en_l_q[k_q] ? ACC_W'(prod) : '0;
    assign add_r = en_r_q[k_q] ? ACC_W'(prod) : '0;
    // Master gain is (m+1)/8, so the multiplier spans 1..8 before the shift.
    assign sc_l  = (SW'(acc_l_q) * SW'($signed({2'b0, mst_l_q} + 5'd1))) >>> SCALE_SHIFT;
    assign sc_r  = (SW'(acc_r_q) * SW'($signed({2'b0, mst_r_q} + 5'd1))) >>> SCALE_SHIFT;

    audio_sat #(.IN_W(SW), .OUT_W(OUT_W)) u_sat_l (.d_i(sc_l), .q_o(sat_l));
    audio_sat #(.IN_W(SW), .OUT_W(OUT_W)) u_sat_r (.d_i(sc_r), .q_o(sat_r));

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // A drop outranks a clear; ticks are only accepted in IDLE.
            overrun_q <= (sample_tick && state_q != IDLE) ? 1'b1 : clr_overrun ? 1'b0 : overrun_q;
            if (!power_en) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_l_q     <= '0;
                out_r_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: if (sample_tick) begin
                        samp_q  <= ch_sample;
                        vol_q   <= ch_vol;
                        en_l_q  <= ch_en_l;
                        en_r_q  <= ch_en_r;
                        mst_l_q <= master_l;
                        mst_r_q <= master_r;
                        acc_l_q <= '0;
                        acc_r_q <= '0;
                        k_q     <= '0;
                        state_q <= ACCUM;
                    end
                    ACCUM: begin
                        acc_l_q <= acc_l_q + add_l;
                        acc_r_q <= acc_r_q + add_r;
                        k_q     <= k_q + 1'b1;
                        if (k_q == KW'(NUM_CH - 1)) state_q <= SCALE;
                    end
                    SCALE: begin
                        out_l_q     <= sat_l;
                        out_r_q     <= sat_r;
                        out_valid_q <= 1'b1;
                        state_q     <= OUTPUT;
                    end
                    OUTPUT: if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_gba_audio_mixer.sv
// tb_gba_audio_mixer: directed checks of the mixer at NUM_CH=4, with a
// second OUT_W=20 instance sharing the stimulus for saturation checks.
module tb_gba_audio_mixer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, sample_tick, power_en, clr_overrun, out_ready;
    logic [63:0]        ch_sample;
    logic [15:0]        ch_vol;
    logic [3:0]         en_l, en_r;
    logic [2:0]         ml, mr;
    logic signed [23:0] ol, orr;
    logic               ov, ovr;
    logic signed [19:0] ol20, or20;
    logic               ov20, ovr20;
    int                 checks = 0, failures = 0;
    int                 lat, seen;

    gba_audio_mixer #(.NUM_CH(4), .IN_W(16), .OUT_W(24)) dut (
        .clk_100(clk), .reset(reset), .sample_tick(sample_tick), .power_en(power_en),
        .ch_sample(ch_sample), .ch_vol(ch_vol), .ch_en_l(en_l), .ch_en_r(en_r),
        .master_l(ml), .master_r(mr), .clr_overrun(clr_overrun),
        .out_l(ol), .out_r(orr), .out_valid(ov), .out_ready(out_ready), .overrun(ovr));

    gba_audio_mixer #(.NUM_CH(4), .IN_W(16), .OUT_W(20)) dut20 (
        .clk_100(clk), .reset(reset), .sample_tick(sample_tick), .power_en(power_en),
        .ch_sample(ch_sample), .ch_vol(ch_vol), .ch_en_l(en_l), .ch_en_r(en_r),
        .master_l(ml), .master_r(mr), .clr_overrun(clr_overrun),
        .out_l(ol20), .out_r(or20), .out_valid(ov20), .out_ready(out_ready), .overrun(ovr20));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [15:0] s, input logic [3:0] v);
        ch_sample[i*16 +: 16] = s;
        ch_vol[i*4 +: 4]      = v;
    endtask

    task automatic clear_ch();
        ch_sample = '0;
        ch_vol    = '0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ov && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // lat counts rising edges from the accepting edge to the cycle out_valid is seen.
    task automatic tick_wait(output int l);
        int n;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        wait_valid(n);
        l = n + 1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic count_valid(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ov) c++;
        end
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0; power_en = 1'b1; clr_overrun = 1'b0; out_ready = 1'b0;
        ch_sample = '0; ch_vol = '0; en_l = '0; en_r = '0; ml = '0; mr = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_l", ol, 0);
        chk("rst_out_r", orr, 0);
        chk("rst_valid", {31'b0, ov}, 0);
        chk("rst_overrun", {31'b0, ovr}, 0);
        reset = 1'b0;

        set_ch(0, 16'd1000, 4'd15); en_l = 4'b0001; en_r = 4'b0000; ml = 3'd7; mr = 3'd7;
        tick_wait(lat);
        chk("single_latency", lat, 6);
        chk("single_l", ol, 15000);
        chk("single_r", orr, 0);
        handshake();
        chk("single_valid_drop", {31'b0, ov}, 0);

        ml = 3'd3;
        tick_wait(lat);
        chk("master3_l", ol, 7500);
        handshake();

        set_ch(0, 16'd1000, 4'd15); set_ch(1, -16'sd2000, 4'd3);
        set_ch(2, 16'd123, 4'd0);   set_ch(3, -16'sd7, 4'd1);
        en_l = 4'b1101; en_r = 4'b0111; ml = 3'd7; mr = 3'd0;
        tick_wait(lat);
        chk("mixed_l", ol, 14993);
        chk("mixed_r", orr, 1125);
        handshake();

        clear_ch(); set_ch(0, -16'sd1001, 4'd1); en_l = 4'b0001; en_r = 4'b0001; ml = 3'd0; mr = 3'd1;
        tick_wait(lat);
        chk("neg_shift_l", ol, -126);
        chk("neg_shift_r", orr, -251);
        handshake();

        for (int i = 0; i < 4; i++) set_ch(i, 16'h7fff, 4'd15);
        en_l = 4'hf; en_r = 4'hf; ml = 3'd7; mr = 3'd7;
        tick_wait(lat);
        chk("sat_pos_wide_l", ol, 1966020);
        chk("sat_pos_l", ol20, 524287);
        chk("sat_pos_r", or20, 524287);
        handshake();
        for (int i = 0; i < 4; i++) set_ch(i, 16'h8000, 4'd15);
        tick_wait(lat);
        chk("sat_neg_wide_r", orr, -1966080);
        chk("sat_neg_l", ol20, -524288);
        chk("sat_neg_r", or20, -524288);
        handshake();

        clear_ch(); set_ch(0, 16'd1000, 4'd15); en_l = 4'b0001; en_r = 4'b0000; ml = 3'd7; mr = 3'd7;
        tick_wait(lat);
        for (int i = 0; i < 10; i++) begin
            sample_tick = (i == 2);
            @(negedge clk);
            chk("stall_l", ol, 15000);
            chk("stall_valid", {31'b0, ov}, 1);
        end
        sample_tick = 1'b0;
        chk("stall_overrun", {31'b0, ovr}, 1);
        handshake();
        count_valid(12, seen);
        chk("stall_no_second", seen, 0);

        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("clr_overrun", {31'b0, ovr}, 0);

        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); clr_overrun = 1'b1;
        @(negedge clk); sample_tick = 1'b0; clr_overrun = 1'b0;
        chk("drop_beats_clr", {31'b0, ovr}, 1);
        wait_valid(seen);
        chk("drop_mix_valid", {31'b0, ov}, 1);
        handshake();
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;

        tick_wait(lat);
        out_ready = 1'b1; sample_tick = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; sample_tick = 1'b0;
        chk("hs_tick_overrun", {31'b0, ovr}, 1);
        count_valid(12, seen);
        chk("hs_tick_dropped", seen, 0);

        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk); power_en = 1'b0;
        count_valid(12, seen);
        chk("pwr_no_valid", seen, 0);
        chk("pwr_out_l_zero", ol, 0);
        chk("pwr_overrun_kept", {31'b0, ovr}, 1);
        power_en = 1'b1;
        tick_wait(lat);
        chk("pwr_resume_lat", lat, 6);
        chk("pwr_resume_l", ol, 15000);
        handshake();

        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0; set_ch(0, -16'sd5, 4'd15); ml = 3'd0; en_l = 4'b0000;
        wait_valid(seen);
        chk("snapshot_l", ol, 15000);
        chk("snapshot_r", orr, 0);
        handshake();

        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        count_valid(12, seen);
        chk("rst_mid_no_valid", seen, 0);
        chk("rst_mid_out_l", ol, 0);
        chk("rst_mid_overrun", {31'b0, ovr}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gba_audio_mixer.md
GBA_AUDIO_MIXER -- requirements
Module: gba_audio_mixer

Interface
REQ-001 Parameter NUM_CH, default 6, meaning channel count (4 PSG + 2 DMA); legal range 1..16.
REQ-002 Parameter IN_W, default 16, meaning signed input sample width.
REQ-003 Parameter OUT_W, default 24, meaning signed output sample width to the codec path.
REQ-004 clk_100  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_tick  in  1  one-cycle 48 kHz mix request strobe.
REQ-007 power_en  in  1  master sound enable (NR52 bit 7).
REQ-008 ch_sample  in  NUM_CH x IN_W  signed per-channel samples.
REQ-009 ch_vol  in  NUM_CH x 4  unsigned per-channel volume, 0..15.
REQ-010 ch_en_l / ch_en_r  in  NUM_CH each  per-channel left/right routing enables.
REQ-011 master_l / master_r  in  3 each  master volume, 0..7.
REQ-012 clr_overrun  in  1  clears the overrun flag.
REQ-013 out_l / out_r  out  OUT_W each  signed mixed samples.
REQ-014 out_valid  out  1  the output pair is valid.
REQ-015 out_ready  in  1  the consumer accepts the pair.
REQ-016 overrun  out  1  sticky flag: a tick was dropped.

Function
REQ-017 FSM states SHALL be IDLE, ACCUM, SCALE and OUTPUT.
REQ-018 IDLE + sample_tick + power_en: snapshot all ch_* and master_* inputs into registers, clear both accumulators, load index k=0, go to ACCUM.
REQ-019 ACCUM: one channel per cycle; acc_l += ch_en_l[k] ? sample[k]*vol[k] : 0 (vol zero-extended, signed multiply); acc_r likewise; after k=NUM_CH-1, go to SCALE.
REQ-020 Accumulator width SHALL be IN_W+5+clog2(NUM_CH)+3; no internal overflow is permitted.
REQ-021 SCALE: result = (acc * (master+1)) >>> 3 (arithmetic shift), saturated to signed OUT_W range, registered into out_l/out_r; go to OUTPUT.
REQ-022 OUTPUT: assert out_valid; out_l/out_r SHALL be held stable until the cycle out_valid && out_ready; then return to IDLE.
REQ-023 Latency: a tick accepted in cycle T SHALL produce out_valid in cycle T+NUM_CH+2.
REQ-024 A sample_tick outside IDLE SHALL be dropped and SHALL set overrun; a tick arriving in the same cycle as handshake completion SHALL also be dropped.
REQ-025 clr_overrun SHALL clear overrun the next cycle; a simultaneous drop SHALL win, leaving overrun at 1.
REQ-026 power_en low in any state SHALL force IDLE, deassert out_valid and zero out_l/out_r the next cycle; overrun SHALL be retained.
REQ-027 Input changes after the snapshot SHALL NOT affect the sample in flight.

Reset
REQ-028 On reset, the FSM SHALL enter IDLE, and out_l, out_r, out_valid, overrun, the accumulators and k SHALL all be 0.
REQ-029 A reset asserted mid-mix SHALL abort the mix with no output produced.

Structure
REQ-030 The state enum and the SCALE shift constant (3) SHALL live in the shared package audio_pkg.
REQ-031 Saturation SHALL be a sub-module, audio_sat, parametrised by input and output width, with one instance per side.

Verification (NUM_CH=4, IN_W=16, OUT_W=24 unless noted)
REQ-032 Single channel: ch0=1000, vol=15, en_l only, master_l=7 -> out_l=15000, out_r=0, out_valid at T+6.
REQ-033 Saturation (OUT_W=20): all channels at 32767, vol 15, both sides, master 7 -> out=524287; all channels at -32768 -> out=-524288.
REQ-034 Backpressure: out_ready held low for 10 cycles -> out_l/out_r stable and out_valid high throughout; a tick during the stall sets overrun and no second output is produced.
REQ-035 Mid-mix power_en drop at T+2 -> out_valid never asserts, outputs 0; the next tick after power returns mixes normally.
REQ-036 Snapshot: change ch_sample at T+1 -> output matches the values present at T.
